// File: rtl/clock12_pkg.sv
// -----------------------------------------------------------------------------
// clock12_pkg
// Shared types and default limits for the 12-hour clock controller.
//   state_t            : control FSM encoding (RUN / SET_HR / SET_MIN)
//   SEC_MAX / MIN_MAX  : last seconds / minutes value before wrap
//   HR_MAX             : last hours value before wrap (mod-12 hours)
//   *_W                : output field widths
// -----------------------------------------------------------------------------
package clock12_pkg;

  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;
  localparam int HR_MAX  = 11;

  localparam int SEC_W = 6;
  localparam int MIN_W = 6;
  localparam int HR_W  = 4;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2
  } state_t;

endpackage : clock12_pkg

// File: rtl/mod_n_counter.sv
// -----------------------------------------------------------------------------
// mod_n_counter
// Modulo-(MAX+1) up-counter with synchronous clear.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset (count -> 0)
//   en    : advance by one this cycle (wraps MAX -> 0)
//   clr   : force count to 0 this cycle (wins over en)
//   count : registered count value 0..MAX
//   wrap  : combinational; high when en is set while count == MAX,
//           i.e. this edge wraps. Used as the carry into the next field.
// -----------------------------------------------------------------------------
module mod_n_counter #(
  parameter int MAX = 59,
  parameter int W   = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] r_count;

  // The carry is reported even when clr also fires, so a field cleared on
  // the same edge still passes its carry upward.
  assign wrap  = en && (r_count == MAX_V);
  assign count = r_count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= wrap ? '0 : r_count + W'(1);
    end
  end

endmodule : mod_n_counter

// File: rtl/clock12_ctrl.sv
// -----------------------------------------------------------------------------
// clock12_ctrl
// 12-hour clock with AM/PM flag and a three-state set/run control FSM.
//   clk       : clock, rising edge
//   reset     : asynchronous active-low reset
//   tick      : 1 Hz timebase enable pulse (counted only in RUN)
//   mode      : advances FSM RUN -> SET_HR -> SET_MIN -> RUN
//   inc       : increments the field being set (hours or minutes)
//   seconds   : 0..SEC_MAX
//   minutes   : 0..MIN_MAX
//   hours     : 0..HR_MAX
//   pm        : 0 = AM, 1 = PM
//   state     : current FSM encoding (RUN=0, SET_HR=1, SET_MIN=2)
//   day_pulse : one-cycle pulse when a tick rolls PM back to AM
// All outputs are registered; an input pulse is visible after the edge that
// samples it. Inputs are level-sampled: a held pulse counts once per cycle.
// -----------------------------------------------------------------------------
module clock12_ctrl #(
  parameter int SEC_MAX = clock12_pkg::SEC_MAX,
  parameter int MIN_MAX = clock12_pkg::MIN_MAX,
  parameter int HR_MAX  = clock12_pkg::HR_MAX
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       mode,
  input  logic       inc,
  output logic [5:0] seconds,
  output logic [5:0] minutes,
  output logic [3:0] hours,
  output logic       pm,
  output logic [1:0] state,
  output logic       day_pulse
);

  import clock12_pkg::state_t;
  import clock12_pkg::RUN;
  import clock12_pkg::SET_HR;
  import clock12_pkg::SET_MIN;
  import clock12_pkg::SEC_W;
  import clock12_pkg::MIN_W;
  import clock12_pkg::HR_W;

  state_t r_state;
  state_t w_next_state;

  logic r_pm;
  logic r_day_pulse;

  logic w_run;
  logic w_sec_en;
  logic w_sec_clr;
  logic w_min_en;
  logic w_hr_en;

  logic w_sec_wrap;
  logic w_min_wrap;
  logic w_hr_wrap;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. The unused encoding falls back to RUN.
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default first so no path through
  // the block leaves it unassigned, which would infer a latch.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      RUN:     if (mode) w_next_state = SET_HR;
      SET_HR:  if (mode) w_next_state = SET_MIN;
      SET_MIN: if (mode) w_next_state = RUN;
      default:           w_next_state = RUN;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output decode -> counter enables and carry gating.
  // In RUN the chain is tick -> seconds -> minutes -> hours. In the SET states
  // inc drives only the selected field, a coincident mode pulse wins over inc,
  // and a minutes wrap while setting never carries into hours.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_run     = (r_state == RUN);
    w_sec_en  = w_run && tick;
    w_sec_clr = w_run && mode;
    w_min_en  = w_sec_wrap ||
                ((r_state == SET_MIN) && inc && !mode);
    w_hr_en   = (w_run && w_min_wrap) ||
                ((r_state == SET_HR) && inc && !mode);
  end

  // ---------------------------------------------------------------------------
  // Time fields
  // ---------------------------------------------------------------------------
  mod_n_counter #(.MAX(SEC_MAX), .W(SEC_W)) u_sec (
    .clk   (clk),
    .rst_n (reset),
    .en    (w_sec_en),
    .clr   (w_sec_clr),
    .count (seconds),
    .wrap  (w_sec_wrap)
  );

  mod_n_counter #(.MAX(MIN_MAX), .W(MIN_W)) u_min (
    .clk   (clk),
    .rst_n (reset),
    .en    (w_min_en),
    .clr   (1'b0),
    .count (minutes),
    .wrap  (w_min_wrap)
  );

  mod_n_counter #(.MAX(HR_MAX), .W(HR_W)) u_hr (
    .clk   (clk),
    .rst_n (reset),
    .en    (w_hr_en),
    .clr   (1'b0),
    .count (hours),
    .wrap  (w_hr_wrap)
  );

  // ---------------------------------------------------------------------------
  // AM/PM flag and day pulse. Any hours wrap flips pm; only a wrap caused by
  // timekeeping (RUN) while in PM marks the start of a new day.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pm        <= 1'b0;
      r_day_pulse <= 1'b0;
    end else begin
      if (w_hr_wrap) begin
        r_pm <= ~r_pm;
      end
      r_day_pulse <= w_run && w_hr_wrap && r_pm;
    end
  end

  assign pm        = r_pm;
  assign day_pulse = r_day_pulse;
  assign state     = r_state;

endmodule : clock12_ctrl

// File: tb/tb_clock12_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clock12_ctrl
// Self-checking bench for clock12_ctrl. Each stimulus cycle runs a small
// behavioural clock model, pushes the expected outputs to a scoreboard queue,
// and the entry is popped and compared one edge later.
// -----------------------------------------------------------------------------
module tb_clock12_ctrl;

  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;
  localparam int HR_MAX  = 11;

  localparam int ST_RUN     = 0;
  localparam int ST_SET_HR  = 1;
  localparam int ST_SET_MIN = 2;

  logic       clk;
  logic       reset;
  logic       tick;
  logic       mode;
  logic       inc;
  logic [5:0] seconds;
  logic [5:0] minutes;
  logic [3:0] hours;
  logic       pm;
  logic [1:0] state;
  logic       day_pulse;

  typedef struct {
    int s;
    int m;
    int h;
    int pm;
    int st;
    int day;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  int ms  = 0;
  int mm  = 0;
  int mh  = 0;
  int mpm = 0;
  int mst = ST_RUN;

  clock12_ctrl #(
    .SEC_MAX (SEC_MAX),
    .MIN_MAX (MIN_MAX),
    .HR_MAX  (HR_MAX)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .mode      (mode),
    .inc       (inc),
    .seconds   (seconds),
    .minutes   (minutes),
    .hours     (hours),
    .pm        (pm),
    .state     (state),
    .day_pulse (day_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic compare_outputs(input exp_t e);
    check("seconds",   int'(seconds),   e.s);
    check("minutes",   int'(minutes),   e.m);
    check("hours",     int'(hours),     e.h);
    check("pm",        int'(pm),        e.pm);
    check("state",     int'(state),     e.st);
    check("day_pulse", int'(day_pulse), e.day);
  endtask

  // One clock cycle of stimulus: model the expected result, queue it, then
  // compare against the DUT just after the edge that samples the inputs.
  task automatic step(input logic t, input logic m, input logic i);
    exp_t e;
    exp_t got_e;
    int   nst;
    @(negedge clk);
    tick = t;
    mode = m;
    inc  = i;
    e.day = 0;
    nst   = mst;
    case (mst)
      ST_RUN: begin
        if (t) begin
          if (ms == SEC_MAX) begin
            ms = 0;
            if (mm == MIN_MAX) begin
              mm = 0;
              if (mh == HR_MAX) begin
                mh = 0;
                if (mpm == 1) e.day = 1;
                mpm = 1 - mpm;
              end else begin
                mh = mh + 1;
              end
            end else begin
              mm = mm + 1;
            end
          end else begin
            ms = ms + 1;
          end
        end
        if (m) begin
          ms  = 0;
          nst = ST_SET_HR;
        end
      end
      ST_SET_HR: begin
        if (m) begin
          nst = ST_SET_MIN;
        end else if (i) begin
          if (mh == HR_MAX) begin
            mh  = 0;
            mpm = 1 - mpm;
          end else begin
            mh = mh + 1;
          end
        end
      end
      ST_SET_MIN: begin
        if (m) begin
          nst = ST_RUN;
        end else if (i) begin
          mm = (mm == MIN_MAX) ? 0 : mm + 1;
        end
      end
      default: nst = ST_RUN;
    endcase
    mst  = nst;
    e.s  = ms;
    e.m  = mm;
    e.h  = mh;
    e.pm = mpm;
    e.st = mst;
    exp_q.push_back(e);

    @(posedge clk);
    #1;
    tick = 1'b0;
    mode = 1'b0;
    inc  = 1'b0;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 1, 0);
    end else begin
      got_e = exp_q.pop_front();
      compare_outputs(got_e);
    end
  endtask

  task automatic repeat_step(input int n, input logic t, input logic m, input logic i);
    for (int k = 0; k < n; k++) step(t, m, i);
  endtask

  task automatic model_reset();
    ms  = 0;
    mm  = 0;
    mh  = 0;
    mpm = 0;
    mst = ST_RUN;
    exp_q.delete();
  endtask

  initial begin
    exp_t z;
    reset = 1'b0;
    tick  = 1'b0;
    mode  = 1'b0;
    inc   = 1'b0;
    model_reset();
    z = '{s: 0, m: 0, h: 0, pm: 0, st: ST_RUN, day: 0};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    compare_outputs(z);
    @(negedge clk);
    reset = 1'b1;

    // basic counting, inc ignored in RUN, held tick counted once per cycle
    repeat_step(3, 1'b1, 1'b0, 1'b0);
    repeat_step(2, 1'b0, 1'b0, 1'b1);
    repeat_step(2, 1'b1, 1'b0, 1'b1);

    // hour wrap while setting: 11 AM -> 0 PM, no day pulse
    step(1'b0, 1'b1, 1'b0);              // RUN -> SET_HR, seconds cleared
    repeat_step(11, 1'b0, 1'b0, 1'b1);   // hours = 11, AM
    step(1'b0, 1'b0, 1'b1);              // hours = 0, PM

    // mode and inc together: mode wins, hours untouched
    step(1'b0, 1'b1, 1'b1);              // -> SET_MIN

    // ticks frozen while setting
    repeat_step(10, 1'b1, 1'b0, 1'b0);

    // minutes wrap while setting does not carry into hours
    repeat_step(59, 1'b0, 1'b0, 1'b1);   // minutes = 59
    step(1'b0, 1'b0, 1'b1);              // minutes = 0, hours unchanged
    step(1'b0, 1'b1, 1'b0);              // -> RUN

    // full-day rollover: preload 11:59:59 PM
    step(1'b0, 1'b1, 1'b0);              // -> SET_HR
    repeat_step(11, 1'b0, 1'b0, 1'b1);   // hours = 11, PM
    step(1'b0, 1'b1, 1'b0);              // -> SET_MIN
    repeat_step(59, 1'b0, 1'b0, 1'b1);   // minutes = 59
    step(1'b0, 1'b1, 1'b0);              // -> RUN
    repeat_step(59, 1'b1, 1'b0, 1'b0);   // seconds = 59
    step(1'b1, 1'b0, 1'b0);              // 00:00:00 AM, day_pulse
    step(1'b1, 1'b0, 1'b0);              // day_pulse drops

    // set sequence from 05:10:33
    step(1'b0, 1'b1, 1'b0);
    repeat_step(5, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    repeat_step(10, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    repeat_step(33, 1'b1, 1'b0, 1'b0);   // 05:10:33 AM
    step(1'b0, 1'b1, 1'b0);              // seconds = 0, SET_HR
    repeat_step(3, 1'b0, 1'b0, 1'b1);    // hours = 8
    step(1'b0, 1'b1, 1'b0);              // SET_MIN
    repeat_step(55, 1'b0, 1'b0, 1'b1);   // minutes = 5
    step(1'b0, 1'b1, 1'b0);              // RUN

    // reset mid-count at 03:25:40 PM
    step(1'b0, 1'b1, 1'b0);
    repeat_step(7, 1'b0, 1'b0, 1'b1);    // 8 AM + 7 -> 3 PM
    step(1'b0, 1'b1, 1'b0);
    repeat_step(20, 1'b0, 1'b0, 1'b1);   // minutes = 25
    step(1'b0, 1'b1, 1'b0);
    repeat_step(40, 1'b1, 1'b0, 1'b0);   // 03:25:40 PM
    check("pre_reset_hours", int'(hours), 3);
    check("pre_reset_pm",    int'(pm),    1);
    @(negedge clk);
    #2;
    tick  = 1'b1;
    reset = 1'b0;
    #1;
    compare_outputs(z);                  // asynchronous, before any edge
    @(posedge clk);
    #1;
    compare_outputs(z);                  // held in reset despite tick
    @(negedge clk);
    tick  = 1'b0;
    reset = 1'b1;
    model_reset();

    // first tick after reset counts
    step(1'b1, 1'b0, 1'b0);
    repeat_step(2, 1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_clock12_ctrl
